// File: rtl/config_frame_writer.sv
// config_frame_writer: assembles one frame of bitstream words and strobes a single config latch column/frame.
// Optional feature: define CONFIG_FRAME_CHECKSUM_EN to require an XOR trailer word before the strobe.
module config_frame_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfColumns = 16,
    parameter int StrobeCycles    = 2
) (
    input  logic                                        CLK,
    input  logic                                        resetn,
    input  logic [FrameBitsPerRow-1:0]                  s_data,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic                                        err_clear,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]     FrameData,
    output logic [MaxFramesPerCol*NumberOfColumns-1:0]  FrameStrobe,
    output logic                                        busy,
    output logic                                        error,
    output logic [15:0]                                 frames_written
);
    localparam int RowW = $clog2(NumberOfRows);
    localparam int ColW = $clog2(NumberOfColumns);
    localparam int FrmW = $clog2(MaxFramesPerCol);
    localparam int StbN = MaxFramesPerCol * NumberOfColumns;
    localparam int StbW = $clog2(StbN);
    localparam logic [RowW-1:0] LastRow  = RowW'(NumberOfRows - 1);
    localparam logic [3:0]      LastStb  = 4'(StrobeCycles - 1);
    localparam logic [7:0]      ColLimit = 8'(NumberOfColumns);
    localparam logic [7:0]      FrmLimit = 8'(MaxFramesPerCol);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef CONFIG_FRAME_CHECKSUM_EN
        CHECK,
`endif
        SETUP,
        STROBE,
        HOLD
    } stateT;

    stateT state, nextState;
    logic readyEn, accept, hdrOk, errEvent, takesWords;
    logic [RowW-1:0] wordCnt;
    logic [ColW-1:0] colReg;
    logic [FrmW-1:0] frmReg;
    logic [3:0] stbCnt;
    logic [15:0] fwCnt;
    logic [StbW-1:0] strobeIdx;
`ifdef CONFIG_FRAME_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] xorAcc;
    assign takesWords = (state == IDLE) || (state == LOAD) || (state == CHECK);
`else
    assign takesWords = (state == IDLE) || (state == LOAD);
`endif

    // readyEn holds s_ready low for the reset cycle only
    assign s_ready = readyEn && takesWords;
    assign accept  = s_valid && s_ready;
    assign hdrOk   = (s_data[31:24] == 8'hFA) && (s_data[23:16] < ColLimit) &&
                     (s_data[15:8] == 8'h00) && (s_data[7:0] < FrmLimit);
    assign busy    = (state != IDLE);
    assign frames_written = fwCnt;
    assign strobeIdx = StbW'(colReg) * StbW'(MaxFramesPerCol) + StbW'(frmReg);
    // decoded from the async-reset state, so reset drops the strobe without a clock
    assign FrameStrobe = (state == STROBE) ? (StbN'(1) << strobeIdx) : '0;

    // state register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    // next-state decode and error event detection
    always_comb begin
        nextState = state;
        errEvent  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && hdrOk) nextState = LOAD;
                errEvent = accept && !hdrOk;
            end
`ifdef CONFIG_FRAME_CHECKSUM_EN
            LOAD:  if (accept && wordCnt == LastRow) nextState = CHECK;
            CHECK: if (accept) begin
                nextState = (s_data == xorAcc) ? SETUP : IDLE;
                errEvent  = (s_data != xorAcc);
            end
`else
            LOAD:  if (accept && wordCnt == LastRow) nextState = SETUP;
`endif
            SETUP:   nextState = STROBE;
            STROBE:  if (stbCnt == LastStb) nextState = HOLD;
            HOLD:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // datapath: header latch, row slice writes, strobe timer, error flag, frame counter
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            readyEn   <= 1'b0;
            error     <= 1'b0;
            FrameData <= '0;
            wordCnt   <= '0;
            colReg    <= '0;
            frmReg    <= '0;
            stbCnt    <= '0;
            fwCnt     <= '0;
`ifdef CONFIG_FRAME_CHECKSUM_EN
            xorAcc    <= '0;
`endif
        end else begin
            readyEn <= 1'b1;
            error   <= errEvent || (error && !err_clear);
            if (state == IDLE && accept && hdrOk) begin
                colReg  <= s_data[16 +: ColW];
                frmReg  <= s_data[0 +: FrmW];
                wordCnt <= '0;
`ifdef CONFIG_FRAME_CHECKSUM_EN
                xorAcc  <= '0;
`endif
            end
            if (state == LOAD && accept) begin
                FrameData[wordCnt*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                wordCnt <= wordCnt + 1'b1;
`ifdef CONFIG_FRAME_CHECKSUM_EN
                xorAcc  <= xorAcc ^ s_data;
`endif
            end
            stbCnt <= (state == STROBE) ? stbCnt + 1'b1 : 4'd0;
            if (state == HOLD) fwCnt <= fwCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_config_frame_writer.sv
// tb_config_frame_writer: directed checks of frame assembly, strobe timing, header errors and reset.
module tb_config_frame_writer;
    logic         CLK = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         err_clear = 1'b0;
    logic [511:0] FrameData;
    logic [319:0] FrameStrobe;
    logic         busy;
    logic         error;
    logic [15:0]  frames_written;
    int nAsserts = 0;
    int nFails = 0;
    logic [15:0] fwExp = '0;

    always #5 CLK = ~CLK;

    config_frame_writer dut (
        .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .err_clear(err_clear), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .busy(busy), .error(error), .frames_written(frames_written)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) chk("push_timeout", s_ready, 1);
        tick();
    endtask

    function automatic logic [511:0] mkData(input logic [31:0] base);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[32*k +: 32] = base + 32'(k);
        return d;
    endfunction

    task automatic sendFrame(input logic [31:0] hdr, input logic [31:0] base, input int stallAt, input bit badTrailer);
        logic [31:0] x = '0;
        push(hdr);
        chk("hdr_busy", busy, 1);
        for (int k = 0; k < 16; k++) begin
            push(base + 32'(k));
            x ^= base + 32'(k);
            if (k == stallAt) begin
                s_valid = 1'b0;
                repeat (3) begin
                    chk("stall_busy", busy, 1);
                    chk("stall_ready", s_ready, 1);
                    chk("stall_strobe", FrameStrobe, 0);
                    tick();
                end
            end
        end
`ifdef CONFIG_FRAME_CHECKSUM_EN
        push(badTrailer ? (x ^ 32'h1) : x);
`else
        if (badTrailer) x = '0;
`endif
        s_valid = 1'b0;
    endtask

    task automatic checkStrobe(input int idx, input logic [511:0] expData);
        logic [319:0] e = '0;
        e[idx] = 1'b1;
        chk("setup_strobe", FrameStrobe, 0);
        chk("setup_ready", s_ready, 0);
        chk("setup_data", FrameData, expData);
        tick();
        chk("strobe_1", FrameStrobe, e);
        chk("strobe_1_ready", s_ready, 0);
        tick();
        chk("strobe_2", FrameStrobe, e);
        chk("strobe_2_data", FrameData, expData);
        tick();
        chk("hold_strobe", FrameStrobe, 0);
        chk("hold_ready", s_ready, 0);
        chk("hold_busy", busy, 1);
        tick();
        fwExp = fwExp + 16'd1;
        chk("idle_ready", s_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_strobe", FrameStrobe, 0);
        chk("frames_written", frames_written, fwExp);
        chk("idle_data", FrameData, expData);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_fw", frames_written, 0);
        chk("rst_strobe", FrameStrobe, 0);
        chk("rst_data", FrameData, 0);
        @(negedge CLK);
        resetn = 1'b1;
        #1;
        chk("ready_at_release", s_ready, 0);
        tick();
        chk("ready_first_clock", s_ready, 1);

        // basic frame: column 3, frame 5 -> strobe bit 65
        sendFrame(32'hFA03_0005, 32'h1000_0000, -1, 1'b0);
        checkStrobe(65, mkData(32'h1000_0000));

        // malformed headers: bad sync, column 16, frame 20
        push(32'hFB00_0000);
        chk("badsync_error", error, 1);
        chk("badsync_busy", busy, 0);
        chk("badsync_strobe", FrameStrobe, 0);
        push(32'hFA10_0000);
        chk("badcol_busy", busy, 0);
        chk("badcol_strobe", FrameStrobe, 0);
        push(32'hFA00_0014);
        chk("badfrm_busy", busy, 0);
        chk("badfrm_strobe", FrameStrobe, 0);
        chk("badfrm_error", error, 1);
        chk("bad_fw", frames_written, fwExp);
        chk("bad_data_kept", FrameData, mkData(32'h1000_0000));
        s_valid = 1'b0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", error, 0);
        err_clear = 1'b1;
        push(32'hFA00_0100);
        err_clear = 1'b0;
        s_valid = 1'b0;
        chk("err_event_wins", error, 1);
        chk("reserved_busy", busy, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared_2", error, 0);

        // last column/frame with a 3-cycle stall between words 7 and 8 -> bit 319
        sendFrame(32'hFA0F_0013, 32'hA500_0000, 7, 1'b0);
        checkStrobe(319, mkData(32'hA500_0000));

        // reset during second strobe cycle drops everything without a clock edge
        sendFrame(32'hFA02_0001, 32'h3300_0000, -1, 1'b0);
        tick();
        chk("pre_rst_strobe_1", FrameStrobe, 320'(1) << 41);
        tick();
        chk("pre_rst_strobe_2", FrameStrobe, 320'(1) << 41);
        resetn = 1'b0;
        #1;
        chk("midrst_strobe", FrameStrobe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", s_ready, 0);
        chk("midrst_fw", frames_written, 0);
        chk("midrst_data", FrameData, 0);
        chk("midrst_error", error, 0);
        fwExp = '0;
        @(negedge CLK);
        resetn = 1'b1;
        tick();
        sendFrame(32'hFA01_0002, 32'h4400_0000, -1, 1'b0);
        checkStrobe(22, mkData(32'h4400_0000));

`ifdef CONFIG_FRAME_CHECKSUM_EN
        // XOR of 0..15 is 0: correct trailer strobes, wrong trailer is rejected
        sendFrame(32'hFA00_0000, 32'h0, -1, 1'b0);
        checkStrobe(0, mkData(32'h0));
        sendFrame(32'hFA00_0001, 32'h0, -1, 1'b1);
        chk("cks_error", error, 1);
        chk("cks_busy", busy, 0);
        repeat (4) begin
            chk("cks_no_strobe", FrameStrobe, 0);
            tick();
        end
        chk("cks_fw", frames_written, fwExp);
        chk("cks_data_kept", FrameData, mkData(32'h0));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
`endif

        // frame counter wraps 0xFFFF -> 0
        force dut.fwCnt = 16'hFFFF;
        tick();
        release dut.fwCnt;
        tick();
        fwExp = 16'hFFFF;
        chk("fw_preload", frames_written, 16'hFFFF);
        sendFrame(32'hFA05_0006, 32'h5A00_0000, -1, 1'b0);
        checkStrobe(106, mkData(32'h5A00_0000));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Configuration-path stage directly upstream of every tile's config memory latches.
- Accepts a 32-bit bitstream word stream via valid/ready and assembles one full frame across all rows.
- Drives the fabric-wide FrameData bus, then pulses exactly one FrameStrobe line (one column, one frame index) so the addressed latches capture the data.
- Guarantees data setup and hold around every strobe, as level-sensitive latches require.

Parameters:
- FrameBitsPerRow, 32, bits per row slice of FrameData; also the stream word width.
- MaxFramesPerCol, 20, frames per column (strobe lines per column).
- NumberOfRows, 16, rows in the fabric; data words per frame.
- NumberOfColumns, 16, columns in the fabric.
- StrobeCycles, 2, strobe high duration in clocks; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- s_data  input  FrameBitsPerRow  stream word.
- s_valid  input  1  stream word valid.
- s_ready  output  1  block accepts a word when s_valid && s_ready.
- err_clear  input  1  synchronous clear of the sticky error flag.
- FrameData  output  FrameBitsPerRow*NumberOfRows  frame data bus to all tiles.
- FrameStrobe  output  MaxFramesPerCol*NumberOfColumns  one-hot strobe; bit index = col*MaxFramesPerCol+frame.
- busy  output  1  high in any state other than IDLE.
- error  output  1  sticky error flag.
- frames_written  output  16  count of successfully strobed frames; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): state IDLE; FrameData=0; FrameStrobe=0; s_ready=0 for the reset cycle, then 1 from the first clock after release; busy=0; error=0; frames_written=0. Reset mid-strobe drops FrameStrobe to 0 immediately, with no clock edge required.
- Header word format: [31:24] must equal 8'hFA; [23:16]=column; [15:8] reserved, must be 0; [7:0]=frame index.
- IDLE, s_ready=1, on a header handshake:
  - If the sync byte matches, column<NumberOfColumns, frame<MaxFramesPerCol and reserved==0: latch column and frame, set word counter=0, go to LOAD.
  - Otherwise: set error, drop the word, stay in IDLE.
- LOAD, s_ready=1: data word k (k=0..NumberOfRows-1) is written to FrameData[k*FrameBitsPerRow +: FrameBitsPerRow] on its handshake; other slices keep their previous values. After word NumberOfRows-1 is accepted, go to SETUP (or CHECK with the optional feature). s_valid low stalls LOAD indefinitely with no timeout.
- SETUP, s_ready=0: 1 cycle; FrameData stable, strobe low.
- STROBE, s_ready=0: FrameStrobe[col*MaxFramesPerCol+frame]=1 for exactly StrobeCycles cycles; all other strobe bits 0. FrameData is unchanged throughout.
- HOLD, s_ready=0: 1 cycle with strobe low and FrameData unchanged; frames_written increments here; then go to IDLE.
- Header-to-strobe latency after the last data handshake: strobe rises 2 clocks later (1 SETUP cycle). Total non-accepting gap = 1+StrobeCycles+1 cycles.
- FrameData keeps its last frame contents in IDLE; it is not cleared between frames.
- err_clear:
  - Clears error on the next edge.
  - If an error event occurs in the same cycle, the event wins and error stays 1.
  - Has no effect on the state machine.
- An error never aborts a frame already in LOAD or later.
- FrameStrobe is never multi-hot; at most one bit is high in any cycle.

Optional Feature:
- Macro: CONFIG_FRAME_CHECKSUM_EN.
- Enabled:
  - After the last data word, state CHECK (s_ready=1) accepts one trailer word.
  - A match (trailer == XOR of all NumberOfRows data words) goes to SETUP as normal.
  - A mismatch sets error, issues no strobe, leaves frames_written unchanged and returns to IDLE. FrameData retains the loaded words.
- Disabled: no CHECK state; LOAD goes directly to SETUP; no trailer word is consumed.

Test Plan:
- Reset, then header 0xFA03_0005 followed by 16 words 0x1000_0000+k, s_valid held high -> FrameData[32k+:32]=0x1000_0000+k; FrameStrobe bit 65 only, high for exactly 2 cycles; strobe rises 2 clocks after the last word; frames_written=1; s_ready low for 4 cycles.
- Header 0xFB00_0000, then 0xFA10_0000 (column 16), then 0xFA00_0014 (frame 20) -> error=1 after the first; no strobe at any time; state stays IDLE; all three words accepted. Then err_clear=1 for one cycle -> error=0.
- Valid frame to column 15, frame 19, with s_valid toggled low for 3 cycles between data words 7 and 8 -> FrameStrobe bit 319 only; FrameData correct; busy high from the header through HOLD.
- Assert resetn=0 during the second STROBE cycle -> FrameStrobe=0 the same cycle, with no clock edge; all outputs at reset values; the next frame completes normally.
- With CONFIG_FRAME_CHECKSUM_EN, words 0..15 = k and trailer 0x0000_0000 (the correct XOR) -> strobe issued. Repeat with trailer 0x0000_0001 -> no strobe, error=1, frames_written unchanged.
- Preload frames_written to 0xFFFF by issuing 65535 frames (or via a bench force), then one more frame -> frames_written=0x0000.
